// File: rtl/cache_l1_pkg.sv
// Shared definitions for the parametrised L1 data cache.
// Holds the controller state encoding, the access-size encoding, the
// byte-lane mask helpers used for both load extraction and store lane
// shifting, and the address-field position derivation.
package cache_l1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REFILL,
        WRITE,
        UNC_RD,
        DONE
    } cacheState_t;

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } accessSize_t;

    // Bits 1:0 of every address select the byte inside a 32-bit word.
    localparam int WORD_OFFSET_BITS = 2;

    // Lowest address bit of the tag field.
    function automatic int tagLsb(input int offsetBits, input int indexBits);
        return WORD_OFFSET_BITS + offsetBits + indexBits;
    endfunction

    // A byte request wins over a half request; neither means a word.
    function automatic accessSize_t decodeSize(input logic byteAccess, input logic halfAccess);
        if (byteAccess) return SIZE_BYTE;
        if (halfAccess) return SIZE_HALF;
        return SIZE_WORD;
    endfunction

    // Byte lanes touched across two consecutive words: [3:0] part 0, [7:4] part 1.
    function automatic logic [7:0] laneMask(input accessSize_t size, input logic [1:0] byteOffset);
        logic [7:0] base;
        case (size)
            SIZE_BYTE: base = 8'b0000_0001;
            SIZE_HALF: base = 8'b0000_0011;
            default:   base = 8'b0000_1111;
        endcase
        return base << byteOffset;
    endfunction

    function automatic logic spansTwoWords(input accessSize_t size, input logic [1:0] byteOffset);
        logic [7:0] mask;
        mask = laneMask(size, byteOffset);
        return |mask[7:4];
    endfunction

endpackage

// File: rtl/cache_l1_align.sv
// Combinational byte-lane alignment for the L1 cache.
// Ports:
//   size, byteOffset  access size and address[1:0]
//   unsignedRead      zero-extend (1) or sign-extend (0) loads
//   loadWords         {part1, part0} words feeding a load
//   storeData         right-aligned CPU store data
//   loadResult        extracted and extended load value
//   storeData0/1      store data shifted into the lanes of part 0 / part 1
//   byteEnable0/1     store byte enables for part 0 / part 1
module cache_l1_align
    import cache_l1_pkg::*;
(
    input  accessSize_t  size,
    input  logic [1:0]   byteOffset,
    input  logic         unsignedRead,
    input  logic [63:0]  loadWords,
    input  logic [31:0]  storeData,
    output logic [31:0]  loadResult,
    output logic [31:0]  storeData0,
    output logic [31:0]  storeData1,
    output logic [3:0]   byteEnable0,
    output logic [3:0]   byteEnable1
);

    logic [63:0] shiftedLoad;
    logic [63:0] shiftedStore;
    logic [7:0]  mask;
    logic [31:0] unusedLoadHigh;

    always_comb begin
        // NOTE: every output of this block is assigned before the case so no path leaves it holding a stale value (which would infer a latch).
        shiftedLoad  = loadWords >> {byteOffset, 3'b000};
        shiftedStore = {32'b0, storeData} << {byteOffset, 3'b000};
        mask         = laneMask(size, byteOffset);
        loadResult   = shiftedLoad[31:0];
        case (size)
            SIZE_BYTE: loadResult = {{24{~unsignedRead & shiftedLoad[7]}}, shiftedLoad[7:0]};
            SIZE_HALF: loadResult = {{16{~unsignedRead & shiftedLoad[15]}}, shiftedLoad[15:0]};
            default:   loadResult = shiftedLoad[31:0];
        endcase
    end

    assign unusedLoadHigh = shiftedLoad[63:32];
    assign storeData0     = shiftedStore[31:0];
    assign storeData1     = shiftedStore[63:32];
    assign byteEnable0    = mask[3:0];
    assign byteEnable1    = mask[7:4];

endmodule

// File: rtl/cache_l1_param.sv
// Direct-mapped write-through L1 data cache with multi-word lines.
// Loads hit in zero cycles; misses refill whole lines beat by beat; stores
// always go to memory and update the cached copy only on a hit. Accesses
// crossing a word boundary are split into two parts; addresses with
// UNCACHED_BIT set bypass the arrays.
// Ports:
//   CPU side:    address, readEnable, writeEnable, byteAccess, halfAccess,
//                unsignedRead, dataIn, flush -> dataOut, cacheReady
//   Memory side: memoryAddress, memoryDataOut, memoryByteEnable,
//                memoryReadEnable, memoryWriteEnable <- memoryDataIn, memoryReady
module cache_l1_param
    import cache_l1_pkg::*;
#(
    parameter int INDEX_BITS   = 5,
    parameter int OFFSET_BITS  = 2,
    parameter int TAG_BITS     = 4,
    parameter int UNCACHED_BIT = 31
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [31:0] address,
    input  logic        readEnable,
    input  logic        writeEnable,
    input  logic        byteAccess,
    input  logic        halfAccess,
    input  logic        unsignedRead,
    input  logic [31:0] dataIn,
    input  logic        flush,
    output logic [31:0] dataOut,
    output logic        cacheReady,
    output logic [31:0] memoryAddress,
    output logic [31:0] memoryDataOut,
    output logic [3:0]  memoryByteEnable,
    output logic        memoryReadEnable,
    output logic        memoryWriteEnable,
    input  logic [31:0] memoryDataIn,
    input  logic        memoryReady
);

    localparam int LINES     = 1 << INDEX_BITS;
    localparam int WORDS     = 1 << OFFSET_BITS;
    localparam int INDEX_LSB = WORD_OFFSET_BITS + OFFSET_BITS;
    localparam int TAG_LSB   = tagLsb(OFFSET_BITS, INDEX_BITS);

    cacheState_t            state, nextState;
    logic [LINES-1:0]       validBits;
    logic [TAG_BITS-1:0]    tagArray  [LINES];
    logic [31:0]            dataArray [LINES*WORDS];
    logic [OFFSET_BITS-1:0] beat;
    logic                   partFlag;     // 0: working on part 0, 1: on part 1
    logic [31:0]            uncachedWord;

    accessSize_t size;
    logic [31:0] part0Address, part1Address, partAddress;
    logic [TAG_BITS-1:0]    tag0, tag1, partTag;
    logic [INDEX_BITS-1:0]  index0, index1, partIndex;
    logic [OFFSET_BITS-1:0] word0, word1, partWord;
    logic hit0, hit1, partHit, spans, isUncached, loadHit, lastBeat, secondLine;
    logic refillBeat, storeMerge, unusedAddressBits;
    logic [31:0] storeData0, storeData1;
    logic [3:0]  byteEnable0, byteEnable1;

    assign size         = decodeSize(byteAccess, halfAccess);
    assign part0Address = {address[31:2], 2'b00};
    assign part1Address = part0Address + 32'd4;
    assign partAddress  = partFlag ? part1Address : part0Address;
    assign unusedAddressBits = ^{part0Address, part1Address, partAddress};

    assign tag0      = part0Address[TAG_LSB +: TAG_BITS];
    assign tag1      = part1Address[TAG_LSB +: TAG_BITS];
    assign partTag   = partAddress[TAG_LSB +: TAG_BITS];
    assign index0    = part0Address[INDEX_LSB +: INDEX_BITS];
    assign index1    = part1Address[INDEX_LSB +: INDEX_BITS];
    assign partIndex = partAddress[INDEX_LSB +: INDEX_BITS];
    assign word0     = part0Address[WORD_OFFSET_BITS +: OFFSET_BITS];
    assign word1     = part1Address[WORD_OFFSET_BITS +: OFFSET_BITS];
    assign partWord  = partAddress[WORD_OFFSET_BITS +: OFFSET_BITS];

    assign hit0       = validBits[index0] && (tagArray[index0] == tag0);
    assign hit1       = validBits[index1] && (tagArray[index1] == tag1);
    assign partHit    = validBits[partIndex] && (tagArray[partIndex] == partTag);
    assign spans      = spansTwoWords(size, address[1:0]);
    assign isUncached = address[UNCACHED_BIT];
    assign loadHit    = hit0 && (!spans || hit1);
    assign lastBeat   = (beat == {OFFSET_BITS{1'b1}});
    // Part 1 still needs its own line once part 0's line is in.
    assign secondLine = !partFlag && spans && !hit1 && ((index1 != index0) || (tag1 != tag0));
    assign refillBeat = (state == REFILL) && memoryReady;
    assign storeMerge = (state == WRITE) && memoryReady && !isUncached && partHit;

    cache_l1_align align (
        .size         (size),
        .byteOffset   (address[1:0]),
        .unsignedRead (unsignedRead),
        .loadWords    (isUncached ? {32'b0, uncachedWord}
                                  : {dataArray[{index1, word1}], dataArray[{index0, word0}]}),
        .storeData    (dataIn),
        .loadResult   (dataOut),
        .storeData0   (storeData0),
        .storeData1   (storeData1),
        .byteEnable0  (byteEnable0),
        .byteEnable1  (byteEnable1)
    );

    assign memoryDataOut = partFlag ? storeData1 : storeData0;

    always_comb begin
        nextState         = state;
        cacheReady        = 1'b0;
        memoryReadEnable  = 1'b0;
        memoryWriteEnable = 1'b0;
        memoryByteEnable  = 4'b0000;
        memoryAddress     = partAddress;
        case (state)
            IDLE: begin
                cacheReady = (!readEnable && !writeEnable)
                           || (readEnable && !flush && !isUncached && loadHit);
                if (flush)                         nextState = IDLE;
                else if (readEnable && isUncached) nextState = UNC_RD;
                else if (readEnable && !loadHit)   nextState = REFILL;
                else if (!readEnable && writeEnable) nextState = WRITE;
            end
            REFILL: begin
                memoryReadEnable = 1'b1;
                memoryAddress    = 32'({partTag, partIndex, beat, 2'b00});
                if (memoryReady && lastBeat) nextState = secondLine ? REFILL : DONE;
            end
            WRITE: begin
                memoryWriteEnable = 1'b1;
                memoryByteEnable  = partFlag ? byteEnable1 : byteEnable0;
                if (memoryReady) nextState = (!partFlag && spans && !isUncached) ? WRITE : DONE;
            end
            UNC_RD: begin
                memoryReadEnable = 1'b1;
                memoryAddress    = part0Address;
                if (memoryReady) nextState = DONE;
            end
            DONE: begin
                cacheReady = 1'b1;
                nextState  = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!resetN) state <= IDLE;
        else         state <= nextState;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            validBits <= '0;
            beat      <= '0;
            partFlag  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    beat     <= '0;
                    partFlag <= 1'b0;
                    if (flush) begin
                        validBits <= '0;
                    end else if (readEnable && !isUncached && !loadHit) begin
                        // Part 0 present means only part 1 is missing.
                        partFlag <= hit0;
                        validBits[hit0 ? index1 : index0] <= 1'b0;
                    end
                end
                REFILL: if (memoryReady) begin
                    beat <= beat + OFFSET_BITS'(1);
                    if (lastBeat) begin
                        validBits[partIndex] <= 1'b1;
                        if (secondLine) begin
                            partFlag          <= 1'b1;
                            validBits[index1] <= 1'b0;
                        end
                    end
                end
                WRITE: if (memoryReady && !partFlag && spans && !isUncached) partFlag <= 1'b1;
                DONE:  partFlag <= 1'b0;
                default: ;
            endcase
        end
    end

    // NOTE: tag/data arrays and the uncached capture are not reset; the valid bits alone decide whether array contents mean anything.
    always_ff @(posedge clk) begin
        if (refillBeat) begin
            dataArray[{partIndex, beat}] <= memoryDataIn;
            if (lastBeat) tagArray[partIndex] <= partTag;
        end else if (storeMerge) begin
            for (int b = 0; b < 4; b++) begin
                if (memoryByteEnable[b])
                    dataArray[{partIndex, partWord}][8*b +: 8] <= memoryDataOut[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == UNC_RD && memoryReady) uncachedWord <= memoryDataIn;
    end

endmodule

// File: doc/cache_l1_param.md
Name: cache_l1_param

Overview:
- Parametrised direct-mapped, write-through L1 data cache sitting between the CPU memory stage and the word-wide data memory. Next generation of our L1.
- Adds multi-word lines with burst refill, byte-masked stores and write-hit update instead of invalidate.
- Adds split misaligned loads and stores, an uncached (MMIO) bypass window and a one-cycle flush.

Parameters:
- INDEX_BITS, 5: line count = 2^INDEX_BITS.
- OFFSET_BITS, 2: words per line = 2^OFFSET_BITS.
- TAG_BITS, 4: tag = address[2+OFFSET_BITS+INDEX_BITS +: TAG_BITS].
- UNCACHED_BIT, 31: address bit that selects the uncached bypass.

Ports:
- clk  in  1  clock.
- resetN  in  1  synchronous active-low reset.
- address  in  32  CPU byte address.
- readEnable  in  1  load request.
- writeEnable  in  1  store request (ignored while readEnable=1).
- byteAccess  in  1  8-bit access.
- halfAccess  in  1  16-bit access. If neither byteAccess nor halfAccess is set, the access is a word.
- unsignedRead  in  1  zero-extend loads.
- dataIn  in  32  store data, right-aligned.
- flush  in  1  invalidate all lines.
- dataOut  out  32  load result.
- cacheReady  out  1  request complete / cache idle.
- memoryAddress  out  32  word-aligned memory address.
- memoryDataOut  out  32  store data, lane-shifted.
- memoryByteEnable  out  4  store byte lanes.
- memoryReadEnable  out  1  read beat request.
- memoryWriteEnable  out  1  write request.
- memoryDataIn  in  32  read data.
- memoryReady  in  1  beat/write done, 1-cycle pulse.

Behaviour:
- Reset (resetN=0 at posedge):
  - Outputs and state: all valid bits 0, state IDLE, beat counter 0, part flag 0.
  - memoryReadEnable=0, memoryWriteEnable=0, memoryByteEnable=0.
  - Reset mid-operation aborts it. The line being refilled stays invalid.
- Protocol:
  - The CPU holds the request stable until cacheReady=1.
  - cacheReady = (IDLE & no request) | (IDLE & load hit) | DONE.
  - dataOut is valid whenever readEnable & cacheReady.
- Span rules:
  - A load or store spans two words when the word access has address[1:0]≠0, or the half access has address[1:0]=3.
  - Part 0 = word at address&~3. Part 1 = next word.
  - Part 1 may fall in the next line or at the next index.
- Load hit: every needed word is in a valid line with a matching tag. Completes combinationally in the IDLE cycle (0 latency), with no memory traffic.
- IDLE transitions (priority order):
  1. flush clears all valid bits in one cycle; the request, if any, is evaluated next cycle.
  2. Uncached load -> UNC_RD.
  3. Load miss -> REFILL for the first missing line.
  4. Store -> WRITE part 0.
- REFILL:
  - The line's valid bit is cleared on entry.
  - Beats fetch offsets 0..2^OFFSET_BITS-1 in order. memoryAddress = {tag,index,beat,2'b00}, memoryReadEnable=1.
  - Each memoryReady writes that word and increments beat.
  - On the last beat: set valid and tag. Re-check part 1. If part 1 misses in a different line, refill it; else go to DONE.
- WRITE:
  - memoryWriteEnable=1; byte enables and data are shifted by address[1:0].
  - Part 1 carries the remaining lanes, e.g. word @..01 -> part0 BE=1110, part1 BE=0001.
  - On memoryReady: if the part's line is valid with a matching tag, merge the enabled bytes into the cached word. Misses do not allocate.
  - Then go to part 1 if the access spans two words, else DONE.
- UNC_RD:
  - Single aligned word read. The result is captured in a register; no allocation.
  - Uncached accesses use only the part 0 word; lanes beyond it read as 0. Uncached stores issue part 0 only.
- DONE: lasts 1 cycle, cacheReady=1, then IDLE. A load result is formed from the cache arrays, or from the uncached register.
- Extraction: a 64-bit concatenation of {part1, part0} is shifted by 8·address[1:0]. The result is sign- or zero-extended per unsignedRead.
- memoryReady while not requesting is ignored.
- flush outside IDLE is ignored.

Decomposition:
- Package cache_l1_pkg: state enum (IDLE, REFILL, WRITE, UNC_RD, DONE), access-size encoding, byte-enable/shift function, tag/index/offset width derivations.
- Sub-module cache_l1_align:
  - Combinational load extraction/extension.
  - Store lane-shift and byte-enable generation for both parts.

Test Plan:
- Cold word load @0x40, OFFSET_BITS=2 -> 4 read beats @0x40,0x44,0x48,0x4C, DONE, dataOut=mem[0x40]. Repeat load -> cacheReady same cycle, no memory traffic.
- Misaligned word load @0x4E, lines 0x40 and 0x50 cold -> 8 beats across two lines. dataOut = {mem[0x50][15:0], mem[0x4C][31:16]}.
- Signed byte load 0x80 vs unsignedRead=1 from a cached line -> 0xFFFFFF80 / 0x00000080.
- Store half 0xBEEF @0x43 on a cached line -> write @0x40 BE=1000, write @0x44 BE=0001. A following load half @0x43 hits and returns 0xFFFFBEEF.
- Load @0x80000004 (uncached) twice -> two memory reads, no allocation. flush then load @0x40 -> refill again.
- resetN=0 during beat 2 of a refill -> all memory enables 0 next cycle. A later load of the same line misses and performs a full refill.
